instruction_fetch: RTL and testbench

Fetch stage between the program counter and the instruction decoder. Samples the PC address, issues a single-outstanding read to instruction memory, and captures the returned word into an instruction register. Presents the instruction to decode with a valid/ready handshake, and pulses the PC update interface to advance the PC by one after each successful fetch. Supports pipeline flush and a memory-timeout error.

---
 rtl/instruction_fetch.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: samples the PC, issues one outstanding read to
// instruction memory, captures the returned word and hands it to decode over
// a valid/ready handshake, pulsing the PC to advance by one per fetch.
//
// Ports:
//   clock, reset_enable         rising-edge clock, async active-high reset
//   fetch_enable, flush         fetch permission (level), synchronous flush
//   pc_value                    current PC
//   pc_update_enable/value      one-cycle PC increment request (+1)
//   mem_addr, mem_read_enable   read address and one-cycle read strobe
//   mem_ready, mem_data         memory response
//   instruction, instruction_addr, instruction_valid, decode_ready
//                               decode-side handshake
//   fetch_error                 sticky memory timeout flag
module instruction_fetch #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned MEM_ADDR_SIZE  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                     clock,
  input  logic                     reset_enable,
  input  logic                     fetch_enable,
  input  logic                     flush,
  input  logic [MEM_ADDR_SIZE-1:0] pc_value,
  output logic                     pc_update_enable,
  output logic [WORD_SIZE-1:0]     pc_update_value,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic                     mem_read_enable,
  input  logic                     mem_ready,
  input  logic [WORD_SIZE-1:0]     mem_data,
  output logic [WORD_SIZE-1:0]     instruction,
  output logic [MEM_ADDR_SIZE-1:0] instruction_addr,
  output logic                     instruction_valid,
  input  logic                     decode_ready,
  output logic                     fetch_error
);

  // One spare bit so the counter cannot wrap before reaching a 255 limit.
  localparam int unsigned     CNT_W   = 9;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    HOLD,
    DRAIN
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         wait_cnt;
  logic [CNT_W-1:0]         wait_cnt_inc_c;
  logic                     timeout_c;
  logic [MEM_ADDR_SIZE-1:0] next_pc_c;

  assign wait_cnt_inc_c = wait_cnt + CNT_W'(1);
  assign timeout_c      = (wait_cnt_inc_c >= TIMEOUT);

  // A handshake in the first HOLD cycle coincides with the PC increment
  // landing, so pc_value is still the old PC; forward the pending +1.
  assign next_pc_c = pc_value + MEM_ADDR_SIZE'(pc_update_enable);

  // Fetch FSM with registered outputs.
  always_ff @(posedge clock or posedge reset_enable) begin
    if (reset_enable) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      pc_update_enable  <= 1'b0;
      pc_update_value   <= '0;
      mem_addr          <= '0;
      mem_read_enable   <= 1'b0;
      instruction       <= '0;
      instruction_addr  <= '0;
      instruction_valid <= 1'b0;
      fetch_error       <= 1'b0;
    end else begin
      mem_read_enable  <= 1'b0;
      pc_update_enable <= 1'b0;
      pc_update_value  <= '0;

      case (state)
        IDLE: begin
          if (flush) begin
            instruction_valid <= 1'b0;
            fetch_error       <= 1'b0;
          end else if (fetch_enable && !fetch_error) begin
            state           <= FETCH;
            mem_read_enable <= 1'b1;
            mem_addr        <= next_pc_c;
            wait_cnt        <= '0;
          end
        end

        FETCH: begin
          wait_cnt <= '0;
          if (flush) begin
            // Request already issued: its response must be drained.
            instruction_valid <= 1'b0;
            fetch_error       <= 1'b0;
            state             <= DRAIN;
          end else begin
            state <= WAIT_MEM;
          end
        end

        WAIT_MEM: begin
          wait_cnt <= wait_cnt_inc_c;
          if (flush) begin
            fetch_error <= 1'b0;
            state       <= mem_ready ? IDLE : DRAIN;
          end else if (mem_ready) begin
            instruction       <= mem_data;
            instruction_addr  <= mem_addr;
            instruction_valid <= 1'b1;
            pc_update_enable  <= 1'b1;
            pc_update_value   <= WORD_SIZE'(1);
            state             <= HOLD;
          end else if (timeout_c) begin
            fetch_error <= 1'b1;
            state       <= IDLE;
          end
        end

        HOLD: begin
          if (flush) begin
            instruction_valid <= 1'b0;
            fetch_error       <= 1'b0;
            state             <= IDLE;
          end else if (decode_ready) begin
            instruction_valid <= 1'b0;
            if (fetch_enable) begin
              state           <= FETCH;
              mem_read_enable <= 1'b1;
              mem_addr        <= next_pc_c;
              wait_cnt        <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end

        DRAIN: begin
          // Discard the flushed response; a lost response ends silently.
          wait_cnt <= wait_cnt_inc_c;
          if (mem_ready || timeout_c) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by a
// randomized run scored against a transaction-level model (sequential PC,
// memory image lookup, one PC pulse per delivered instruction).
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset_enable;
  logic        fetch_enable;
  logic        flush;
  logic [7:0]  pc = 8'd0;
  logic        pc_update_enable;
  logic [15:0] pc_update_value;
  logic [7:0]  mem_addr;
  logic        mem_read_enable;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_data = 16'd0;
  logic [15:0] instruction;
  logic [7:0]  instruction_addr;
  logic        instruction_valid;
  logic        decode_ready;
  logic        fetch_error;

  int total = 0;
  int bad   = 0;

  instruction_fetch dut (
    .clock             (clock),
    .reset_enable      (reset_enable),
    .fetch_enable      (fetch_enable),
    .flush             (flush),
    .pc_value          (pc),
    .pc_update_enable  (pc_update_enable),
    .pc_update_value   (pc_update_value),
    .mem_addr          (mem_addr),
    .mem_read_enable   (mem_read_enable),
    .mem_ready         (mem_ready),
    .mem_data          (mem_data),
    .instruction       (instruction),
    .instruction_addr  (instruction_addr),
    .instruction_valid (instruction_valid),
    .decode_ready      (decode_ready),
    .fetch_error       (fetch_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // PC model: adds the requested increment, or loads a bench-chosen value.
  logic       pc_set = 1'b0;
  logic [7:0] pc_set_val = 8'd0;
  always @(posedge clock) begin
    if (pc_set) pc <= pc_set_val;
    else if (pc_update_enable) pc <= pc + pc_update_value[7:0];
  end

  // Memory model: answers mem_lat cycles after the cycle following the strobe.
  logic [15:0] mem [256];
  int          mem_lat  = 0;
  logic        mem_mute = 1'b0;
  logic        pend     = 1'b0;
  int          wcnt     = 0;
  logic [7:0]  raddr    = 8'd0;
  always @(negedge clock) begin
    if (mem_read_enable && !mem_mute) begin
      pend = 1'b1; wcnt = mem_lat; raddr = mem_addr;
      mem_ready = 1'b0; mem_data = 16'($urandom);
    end else if (pend && wcnt == 0) begin
      mem_ready = 1'b1; mem_data = mem[raddr]; pend = 1'b0;
    end else begin
      if (pend) wcnt = wcnt - 1;
      mem_ready = 1'b0; mem_data = 16'($urandom);
    end
  end

  // Observation log: handshakes, read strobes, PC pulses.
  logic [15:0] hs_instr [$];
  logic [7:0]  hs_addr  [$];
  int          hs_cyc   [$];
  logic [7:0]  st_addr  [$];
  int          pulses  = 0;
  int          val_bad = 0;
  always @(negedge clock) begin
    if (instruction_valid && decode_ready) begin
      hs_instr.push_back(instruction);
      hs_addr.push_back(instruction_addr);
      hs_cyc.push_back(cyc);
    end
    if (mem_read_enable) st_addr.push_back(mem_addr);
    if (pc_update_enable) begin
      pulses = pulses + 1;
      if (pc_update_value !== 16'd1) val_bad = val_bad + 1;
    end else if (pc_update_value !== 16'd0) begin
      val_bad = val_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_set = 1'b1; pc_set_val = v;
    tick(1);
    pc_set = 1'b0;
  endtask

  function automatic logic [63:0] outs();
    return 64'({pc_update_enable, pc_update_value, mem_addr, mem_read_enable,
                instruction, instruction_addr, instruction_valid, fetch_error});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, h0, n;
    logic [7:0] r0, ea;

    reset_enable = 1'b1; fetch_enable = 1'b0; flush = 1'b0; decode_ready = 1'b0;
    pc_set = 1'b1; pc_set_val = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(16'h0100 + i);
    tick(2);
    check("reset_outputs", outs(), 64'd0);
    reset_enable = 1'b0; pc_set = 1'b0;
    tick(1);
    check("idle_quiet", outs(), 64'd0);

    // Basic fetch
    mem[0] = 16'hA5A5; p0 = pulses; s0 = st_addr.size();
    decode_ready = 1'b1; fetch_enable = 1'b1;
    tick(1);
    check("t1_strobe", 64'(mem_read_enable), 64'd1);
    check("t1_mem_addr", 64'(mem_addr), 64'h00);
    fetch_enable = 1'b0;
    tick(1);
    check("t1_strobe_one_cycle", 64'(mem_read_enable), 64'd0);
    check("t1_not_valid_yet", 64'(instruction_valid), 64'd0);
    tick(1);
    check("t1_valid", 64'(instruction_valid), 64'd1);
    check("t1_instr", 64'(instruction), 64'hA5A5);
    check("t1_instr_addr", 64'(instruction_addr), 64'h00);
    check("t1_pulse", 64'(pc_update_enable), 64'd1);
    check("t1_pulse_value", 64'(pc_update_value), 64'd1);
    tick(1);
    check("t1_released", 64'(instruction_valid), 64'd0);
    check("t1_pulse_gone", 64'(pc_update_enable), 64'd0);
    check("t1_pc", 64'(pc), 64'h01);
    tick(3);
    check("t1_npulses", 64'(pulses - p0), 64'd1);
    check("t1_nstrobes", 64'(st_addr.size() - s0), 64'd1);
    mem[0] = 16'h0100;

    // Back-to-back, three instructions
    set_pc(8'h00);
    p0 = pulses; s0 = st_addr.size(); h0 = hs_addr.size();
    fetch_enable = 1'b1;
    tick(8);
    fetch_enable = 1'b0;
    tick(4);
    check("t2_nhs", 64'(hs_addr.size() - h0), 64'd3);
    check("t2_npulses", 64'(pulses - p0), 64'd3);
    check("t2_nstrobes", 64'(st_addr.size() - s0), 64'd3);
    for (int k = 0; k < 3; k++) begin
      check("t2_instr", 64'(hs_instr[h0+k]), 64'(16'h0100 + k));
      check("t2_instr_addr", 64'(hs_addr[h0+k]), 64'(k));
      check("t2_mem_addr", 64'(st_addr[s0+k]), 64'(k));
    end
    check("t2_spacing_a", 64'(hs_cyc[h0+1] - hs_cyc[h0]), 64'd3);
    check("t2_spacing_b", 64'(hs_cyc[h0+2] - hs_cyc[h0+1]), 64'd3);

    // Decode stall (pc = 3)
    p0 = pulses; s0 = st_addr.size();
    decode_ready = 1'b0; fetch_enable = 1'b1;
    tick(3);
    check("t3_valid", 64'(instruction_valid), 64'd1);
    check("t3_instr", 64'(instruction), 64'h0103);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("t3_hold_valid", 64'(instruction_valid), 64'd1);
      check("t3_hold_instr", 64'(instruction), 64'h0103);
      check("t3_no_strobe", 64'(mem_read_enable), 64'd0);
    end
    check("t3_npulses", 64'(pulses - p0), 64'd1);
    check("t3_nstrobes", 64'(st_addr.size() - s0), 64'd1);
    check("t3_pc", 64'(pc), 64'h04);
    decode_ready = 1'b1;
    tick(1);
    check("t3_resume_strobe", 64'(mem_read_enable), 64'd1);
    check("t3_resume_addr", 64'(mem_addr), 64'h04);
    check("t3_released", 64'(instruction_valid), 64'd0);
    fetch_enable = 1'b0;
    tick(2);
    check("t3_next_instr", 64'(instruction), 64'h0104);
    tick(1);

    // Timeout (pc = 5)
    mem_mute = 1'b1; p0 = pulses; s0 = st_addr.size();
    fetch_enable = 1'b1;
    tick(1);
    check("t4_strobe", 64'(mem_read_enable), 64'd1);
    check("t4_mem_addr", 64'(mem_addr), 64'h05);
    tick(15);
    check("t4_no_error_early", 64'(fetch_error), 64'd0);
    tick(1);
    check("t4_error", 64'(fetch_error), 64'd1);
    check("t4_not_valid", 64'(instruction_valid), 64'd0);
    tick(5);
    check("t4_blocked", 64'(st_addr.size() - s0), 64'd1);
    check("t4_no_pulse", 64'(pulses - p0), 64'd0);
    check("t4_error_sticky", 64'(fetch_error), 64'd1);
    mem_mute = 1'b0; flush = 1'b1;
    tick(1);
    check("t4_flush_clears", 64'(fetch_error), 64'd0);
    flush = 1'b0;
    tick(1);
    check("t4_refetch_strobe", 64'(mem_read_enable), 64'd1);
    check("t4_refetch_addr", 64'(mem_addr), 64'h05);
    fetch_enable = 1'b0;
    tick(2);
    check("t4_refetch_instr", 64'(instruction), 64'h0105);
    tick(1);

    // Flush while waiting, response arrives two cycles later (pc = 6)
    mem[6] = 16'hDEAD; mem_lat = 2; p0 = pulses;
    fetch_enable = 1'b1;
    tick(1);
    fetch_enable = 1'b0;
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t5_valid_low", 64'(instruction_valid), 64'd0);
      tick(1);
    end
    check("t5_no_pulse", 64'(pulses - p0), 64'd0);
    check("t5_pc_kept", 64'(pc), 64'h06);
    check("t5_no_error", 64'(fetch_error), 64'd0);
    mem_lat = 0;
    set_pc(8'h20);
    fetch_enable = 1'b1;
    tick(1);
    check("t5_next_addr", 64'(mem_addr), 64'h20);
    fetch_enable = 1'b0;
    tick(2);
    check("t5_next_instr", 64'(instruction), 64'h0120);
    tick(1);

    // Flush coinciding with mem_ready returns straight to IDLE (pc = 0x21)
    mem[8'h21] = 16'hBEEF;
    fetch_enable = 1'b1;
    tick(1);
    fetch_enable = 1'b0;
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0; fetch_enable = 1'b1;
    check("t5b_valid_low", 64'(instruction_valid), 64'd0);
    tick(1);
    check("t5b_immediate_fetch", 64'(mem_read_enable), 64'd1);
    check("t5b_addr_same_pc", 64'(mem_addr), 64'h21);
    fetch_enable = 1'b0;
    tick(2);
    check("t5b_instr", 64'(instruction), 64'hBEEF);
    tick(1);

    // Asynchronous reset while holding an instruction (pc = 0x22)
    decode_ready = 1'b0; fetch_enable = 1'b1;
    tick(3);
    check("t6_holding", 64'(instruction_valid), 64'd1);
    #3 reset_enable = 1'b1;
    #1 check("t6_async_reset", outs(), 64'd0);
    tick(1);
    reset_enable = 1'b0; decode_ready = 1'b1;
    check("t6_pc_not_advanced", 64'(pc), 64'h22);
    tick(1);
    check("t6_fetch_strobe", 64'(mem_read_enable), 64'd1);
    check("t6_fetch_addr", 64'(mem_addr), 64'h22);
    fetch_enable = 1'b0;
    tick(2);
    check("t6_instr", 64'(instruction), 64'h0122);
    tick(1);

    // Address wrap across 0xFF
    set_pc(8'hFF);
    h0 = hs_addr.size();
    fetch_enable = 1'b1;
    tick(5);
    fetch_enable = 1'b0;
    tick(4);
    check("t7_nhs", 64'(hs_addr.size() - h0), 64'd2);
    check("t7_addr_ff", 64'(hs_addr[h0]), 64'hFF);
    check("t7_instr_ff", 64'(hs_instr[h0]), 64'h01FF);
    check("t7_addr_00", 64'(hs_addr[h0+1]), 64'h00);
    check("t7_instr_00", 64'(hs_instr[h0+1]), 64'h0100);

    // Randomized run
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    r0 = 8'($urandom);
    set_pc(r0);
    p0 = pulses; s0 = st_addr.size(); h0 = hs_addr.size();
    for (int c = 0; c < 400; c++) begin
      decode_ready = 1'($urandom_range(0, 1));
      fetch_enable = ($urandom_range(0, 3) != 0);
      mem_lat = int'($urandom_range(0, 3));
      tick(1);
    end
    fetch_enable = 1'b0; decode_ready = 1'b1;
    tick(20);
    n = hs_addr.size() - h0;
    check("rnd_progress", 64'(n >= 20), 64'd1);
    check("rnd_npulses", 64'(pulses - p0), 64'(n));
    check("rnd_nstrobes", 64'(st_addr.size() - s0), 64'(n));
    for (int k = 0; k < n; k++) begin
      ea = 8'(r0 + k);
      check("rnd_instr_addr", 64'(hs_addr[h0+k]), 64'(ea));
      check("rnd_instr", 64'(hs_instr[h0+k]), 64'(mem[ea]));
      check("rnd_mem_addr", 64'(st_addr[s0+k]), 64'(ea));
    end
    check("rnd_final_pc", 64'(pc), 64'(8'(r0 + n)));
    check("pc_update_value_rule", 64'(val_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
